// File: rtl/tile_order_reader.sv
// Tile-order consumer: validates a packed order word as a permutation of 0..N_TILES-1,
// then serves its entries one per handshake, with rewind-to-replay.
module tile_order_reader #(
    parameter int unsigned N_TILES = 24,
    parameter int unsigned IDX_W   = 5,
    parameter int unsigned ORDER_W = N_TILES * IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [ORDER_W-1:0] order_in,
    input  logic               rewind,
    input  logic               tile_ready,
    output logic               tile_valid,
    output logic [IDX_W-1:0]   tile_pos,
    output logic [IDX_W-1:0]   tile_idx,
    output logic               tile_last,
    output logic               busy,
    output logic               done,
    output logic               error
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TILES - 1);

    typedef enum logic [2:0] {IDLE, CHECK, SERVE, DONE, ERROR} state_t;

    state_t               state_q, state_d;
    logic [ORDER_W-1:0]   order_q, order_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_TILES-1:0]   seen_q, seen_d;
    logic [IDX_W-1:0]     cur;
    logic                 in_range;
    logic                 dup;
    logic                 valid_d;
    logic [IDX_W-1:0]     pos_d;
    logic [IDX_W-1:0]     idx_out_d;
    logic                 last_d;

    // Entry 0 sits in the most significant IDX_W bits of the word.
    function automatic logic [IDX_W-1:0] entry_at(input logic [ORDER_W-1:0] ord,
                                                  input logic [IDX_W-1:0]   k);
        logic [ORDER_W-1:0] sh;
        sh = ord >> (IDX_W * (N_TILES - 1 - int'(k)));
        return sh[IDX_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            order_q    <= '0;
            idx_q      <= '0;
            seen_q     <= '0;
            tile_valid <= 1'b0;
            tile_pos   <= '0;
            tile_idx   <= '0;
            tile_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            order_q    <= order_d;
            idx_q      <= idx_d;
            seen_q     <= seen_d;
            tile_valid <= valid_d;
            tile_pos   <= pos_d;
            tile_idx   <= idx_out_d;
            tile_last  <= last_d;
            busy       <= (state_d == CHECK);
            done       <= (state_d == DONE);
            error      <= (state_d == ERROR);
        end
    end

    // Next-state logic; load overrides everything, rewind beats the handshake.
    always_comb begin
        state_d  = state_q;
        order_d  = order_q;
        idx_d    = idx_q;
        seen_d   = seen_q;
        cur      = entry_at(order_q, idx_q);
        in_range = (32'(cur) < N_TILES);
        dup      = in_range && seen_q[cur];

        if (load) begin
            order_d = order_in;
            seen_d  = '0;
            idx_d   = '0;
            state_d = CHECK;
        end else begin
            case (state_q)
                CHECK: begin
                    if (!in_range || dup) begin
                        state_d = ERROR;
                    end else begin
                        seen_d[cur] = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = SERVE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                SERVE: begin
                    if (rewind) begin
                        idx_d = '0;
                    end else if (tile_ready) begin
                        if (idx_q == LAST_IDX) state_d = DONE;
                        else                   idx_d   = idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (rewind) begin
                        idx_d   = '0;
                        state_d = SERVE;
                    end
                end
                default: ;
            endcase
        end

        valid_d   = (state_d == SERVE);
        pos_d     = valid_d ? entry_at(order_d, idx_d) : '0;
        idx_out_d = valid_d ? idx_d : '0;
        last_d    = valid_d && (idx_d == LAST_IDX);
    end

endmodule

// File: tb/tb_tile_order_reader.sv
// Randomized scoreboard bench for tile_order_reader against a behavioural order model.
module tb_tile_order_reader;

    localparam int N  = 24;
    localparam int W  = 5;
    localparam int OW = N * W;

    localparam int P_IDLE  = 0;
    localparam int P_CHECK = 1;
    localparam int P_SERVE = 2;
    localparam int P_DONE  = 3;
    localparam int P_ERR   = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          load = 1'b0;
    logic [OW-1:0] order_in = '0;
    logic          rewind = 1'b0;
    logic          tile_ready = 1'b0;
    logic          tile_valid;
    logic [W-1:0]  tile_pos;
    logic [W-1:0]  tile_idx;
    logic          tile_last;
    logic          busy;
    logic          done;
    logic          error;

    tile_order_reader #(.N_TILES(N), .IDX_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .order_in(order_in),
        .rewind(rewind), .tile_ready(tile_ready), .tile_valid(tile_valid),
        .tile_pos(tile_pos), .tile_idx(tile_idx), .tile_last(tile_last),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] pos;
        logic [W-1:0] idx;
        logic         last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: the served order as a plain array plus a phase and counters.
    int   ph = P_IDLE;
    int   cnt = 0;
    int   bad = -1;
    int   midx = 0;
    int   mord[N];
    logic [OW-1:0] word;

    function automatic int ent(input logic [OW-1:0] w, input int k);
        logic [OW-1:0] t;
        t = w >> ((N - 1 - k) * W);
        return int'(t[W-1:0]);
    endfunction

    task automatic set_entry(input int k, input int v);
        word[OW-1-k*W -: W] = W'(v);
    endtask

    task automatic make_identity();
        for (int k = 0; k < N; k++) set_entry(k, k);
    endtask

    task automatic make_random_perm();
        int p[N];
        for (int k = 0; k < N; k++) p[k] = k;
        for (int k = N - 1; k > 0; k--) begin
            int j, t;
            j = int'($urandom_range(k, 0));
            t = p[k]; p[k] = p[j]; p[j] = t;
        end
        for (int k = 0; k < N; k++) set_entry(k, p[k]);
    endtask

    task automatic model_apply(input logic ld, input logic [OW-1:0] o,
                               input logic rw, input logic rdy);
        if (ld) begin
            bit seen[32];
            for (int v = 0; v < 32; v++) seen[v] = 1'b0;
            bad = -1;
            for (int k = 0; k < N; k++) begin
                mord[k] = ent(o, k);
                if (bad < 0) begin
                    if (mord[k] >= N || seen[mord[k]]) bad = k;
                    else seen[mord[k]] = 1'b1;
                end
            end
            ph = P_CHECK; cnt = 0; midx = 0;
        end else begin
            case (ph)
                P_CHECK: begin
                    cnt++;
                    if (bad >= 0 && cnt == bad + 1) ph = P_ERR;
                    else if (bad < 0 && cnt == N) begin ph = P_SERVE; midx = 0; end
                end
                P_SERVE: begin
                    if (rw) midx = 0;
                    else if (rdy) begin
                        if (midx == N - 1) ph = P_DONE;
                        else midx++;
                    end
                end
                P_DONE: if (rw) begin ph = P_SERVE; midx = 0; end
                default: ;
            endcase
        end
    endtask

    task automatic check_flags(input string tag);
        logic eb, ee, ed;
        eb = (ph == P_CHECK); ee = (ph == P_ERR); ed = (ph == P_DONE);
        checks++;
        if (busy !== eb || error !== ee || done !== ed) begin
            failures++;
            $display("FAIL %s flags: got busy=%b error=%b done=%b, want busy=%b error=%b done=%b (t=%0t)",
                     tag, busy, error, done, eb, ee, ed, $time);
        end
    endtask

    // One clock: drive inputs, step the edge, advance the model, queue the expected presentation.
    task automatic cyc(input logic ld, input logic [OW-1:0] o, input logic rw, input logic rdy,
                       input string tag);
        load = ld; order_in = o; rewind = rw; tile_ready = rdy;
        @(posedge clk); #1;
        model_apply(ld, o, rw, rdy);
        check_flags(tag);
        if (ph == P_SERVE) exp_q.push_back('{pos: W'(mord[midx]), idx: W'(midx), last: (midx == N - 1)});
    endtask

    task automatic garbage(output logic [OW-1:0] g);
        for (int k = 0; k < N; k++) g[OW-1-k*W -: W] = W'($urandom);
    endtask

    task automatic run_until_settled(input int max_cyc, input bit ready_toggle, input string tag);
        logic [OW-1:0] g;
        int c;
        c = 0;
        while (c < max_cyc && (ph == P_CHECK || ph == P_SERVE)) begin
            garbage(g);
            cyc(1'b0, g, 1'b0, ready_toggle ? ~c[0] : 1'b1, tag);
            c++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (tile_valid !== 1'b0 || tile_pos !== '0 || tile_idx !== '0 || tile_last !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL %s: got valid=%b pos=%0d idx=%0d last=%b busy=%b done=%b error=%b, want all 0",
                     tag, tile_valid, tile_pos, tile_idx, tile_last, busy, done, error);
        end
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        exp_q.delete();
        ph = P_IDLE; midx = 0; cnt = 0;
        load = 1'b0; rewind = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
    endtask

    // Monitor: every cycle with a valid output or a queued expectation is compared.
    always @(negedge clk) begin
        if (rst_n && (tile_valid || exp_q.size() > 0)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL serve_spurious: got tile_valid=1 pos=%0d idx=%0d, want tile_valid=0 (t=%0t)",
                         tile_pos, tile_idx, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (tile_valid !== 1'b1 || tile_pos !== e.pos || tile_idx !== e.idx || tile_last !== e.last) begin
                    failures++;
                    $display("FAIL serve_entry: got valid=%b pos=%0d idx=%0d last=%b, want valid=1 pos=%0d idx=%0d last=%b (t=%0t)",
                             tile_valid, tile_pos, tile_idx, tile_last, e.pos, e.idx, e.last, $time);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OW-1:0] g;
        #3 check_reset_outputs("reset_initial");
        @(negedge clk); #2 rst_n = 1'b1;

        // Identity order, ready held high.
        make_identity();
        cyc(1'b1, word, 1'b0, 1'b1, "identity_load");
        run_until_settled(80, 1'b0, "identity");
        for (int i = 0; i < 2; i++) cyc(1'b0, '0, 1'b0, 1'b1, "identity_done_hold");

        // Reversed order with ready toggling.
        for (int k = 0; k < N; k++) set_entry(k, N - 1 - k);
        cyc(1'b1, word, 1'b0, 1'b0, "reversed_load");
        run_until_settled(120, 1'b1, "reversed");

        // Duplicate entry, then a valid reload clears the error.
        make_identity(); set_entry(5, 2);
        cyc(1'b1, word, 1'b0, 1'b1, "dup_load");
        run_until_settled(40, 1'b0, "dup");
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b1, "dup_err_rewind");
        make_random_perm();
        cyc(1'b1, word, 1'b0, 1'b1, "dup_reload");
        run_until_settled(80, 1'b0, "dup_reload");

        // Out-of-range at the first and last entry.
        make_identity(); set_entry(0, 31);
        cyc(1'b1, word, 1'b0, 1'b1, "oor_first_load");
        run_until_settled(40, 1'b0, "oor_first");
        make_identity(); set_entry(23, 24);
        cyc(1'b1, word, 1'b0, 1'b1, "oor_last_load");
        run_until_settled(40, 1'b0, "oor_last");

        // Rewind coincident with a handshake at index 10, then rewind from DONE.
        make_random_perm();
        cyc(1'b1, word, 1'b0, 1'b1, "rewind_load");
        for (int c = 0; c < 60 && !(ph == P_SERVE && midx == 10); c++)
            cyc(1'b0, '0, 1'b0, 1'b1, "rewind_pre");
        cyc(1'b0, '0, 1'b1, 1'b1, "rewind_mid");
        run_until_settled(80, 1'b0, "rewind_after");
        cyc(1'b0, '0, 1'b1, 1'b0, "rewind_done");
        run_until_settled(80, 1'b0, "rewind_replay");

        // Reset during CHECK and during SERVE; rewind ignored afterwards.
        make_random_perm();
        cyc(1'b1, word, 1'b0, 1'b1, "rst_check_load");
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b0, 1'b1, "rst_check_pre");
        async_reset("reset_in_check");
        cyc(1'b1, word, 1'b0, 1'b1, "rst_serve_load");
        for (int c = 0; c < 60 && !(ph == P_SERVE && midx == 3); c++)
            cyc(1'b0, '0, 1'b0, 1'b1, "rst_serve_pre");
        async_reset("reset_in_serve");
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 1'b1, "rewind_after_reset");

        // Randomized traffic: permutations, occasional corruption, random ready/rewind/reload.
        for (int it = 0; it < 20; it++) begin
            make_random_perm();
            if ($urandom_range(2, 0) == 0) set_entry(int'($urandom_range(N - 1, 0)), int'($urandom_range(31, 0)));
            cyc(1'b1, word, 1'b0, 1'b1, "rand_load");
            for (int c = 0; c < 70; c++) begin
                logic ld, rw, rdy;
                garbage(g);
                rdy = ($urandom_range(9, 0) < 7);
                rw  = ($urandom_range(19, 0) == 0);
                ld  = ($urandom_range(49, 0) == 0);
                cyc(ld, g, rw, rdy, "rand");
            end
        end

        cyc(1'b0, '0, 1'b0, 1'b0, "final");
        @(negedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tile_order_reader.md
# tile_order_reader

Consumer side of the tile-order generator. It takes one packed tile-order word, which the generator writes as N entries of IDX_W bits each, and checks that the word is a valid permutation of 0..N-1. It then hands the entries out one at a time to the game logic (board placement and flip sequencing) over a valid/ready handshake. It also supports rewinding to replay the same order without reloading.

## Interface
Parameters:
- N_TILES, 24, number of entries in one order word
- IDX_W, 5, bits per entry; must satisfy 2^IDX_W >= N_TILES
- ORDER_W, N_TILES*IDX_W, derived; never overridden

Ports:
- clk  in  1  sole clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- load  in  1  capture order_in and start validation
- order_in  in  ORDER_W  packed order; entry 0 occupies bits [ORDER_W-1 -: IDX_W], entry k occupies [ORDER_W-1-k*IDX_W -: IDX_W]
- rewind  in  1  restart serving from entry 0 without reloading
- tile_ready  in  1  consumer accepts the current entry
- tile_valid  out  1  tile_pos/tile_idx hold a valid entry
- tile_pos  out  IDX_W  value of the current entry (board position)
- tile_idx  out  IDX_W  index of the current entry, 0..N_TILES-1
- tile_last  out  1  current entry is index N_TILES-1 (qualified by tile_valid)
- busy  out  1  validation in progress
- done  out  1  all N_TILES entries accepted
- error  out  1  captured word is not a permutation; sticky

## Operation
- States: IDLE, CHECK, SERVE, DONE, ERROR.
- Internal storage:
  - order register (ORDER_W)
  - index counter (IDX_W)
  - seen bitmap (N_TILES bits)
- IDLE: waits for load. No other input has any effect.
- load accepted in any state, with priority over rewind and the handshake. On load:
  - capture order_in
  - clear the seen bitmap
  - set index to 0
  - clear error and done
  - enter CHECK
- CHECK: one entry per cycle, entry[index].
  - If the value is >= N_TILES, or its seen bit is already set, enter ERROR.
  - Otherwise set the seen bit and increment the index.
  - After entry N_TILES-1 passes, set index to 0 and enter SERVE.
- SERVE: tile_valid=1, tile_pos=entry[index], tile_idx=index, tile_last=(index==N_TILES-1).
  - On tile_valid && tile_ready with index < N_TILES-1: increment the index.
  - On the handshake with index==N_TILES-1: enter DONE.
- DONE: done=1, tile_valid=0. Holds until rewind or load.
- rewind in SERVE or DONE: set index to 0 and go to SERVE. Stored order is kept and not re-validated.
- rewind in IDLE, CHECK or ERROR: ignored.
- rewind coincident with a handshake in SERVE: rewind wins; index becomes 0.
- ERROR: error=1, tile_valid=0, busy=0. Only load or reset leaves it.
- order_in is sampled only on the load cycle; later changes are ignored.
- Index arithmetic is unsigned IDX_W bits. The index never exceeds N_TILES-1, so there is no wrap past N_TILES.

## Timing
- Reset values (asynchronous, immediately on rst_n low):
  - state IDLE
  - tile_valid=0, tile_pos=0, tile_idx=0, tile_last=0
  - busy=0, done=0, error=0
  - order register, index and seen bitmap all 0
- Reset mid-operation in any state returns to IDLE immediately; the stored order is lost.
- All outputs are registered state or a mux of registered state; there is no combinational path from any input to any output.
- Call the rising edge that samples load edge t.
  - busy=1 after edge t.
  - Entry k is checked at edge t+1+k.
  - Valid word: busy=0, tile_valid=1 and tile_idx=0 after edge t+N_TILES.
  - Invalid entry k: error=1 and busy=0 after edge t+1+k.
- Handshake: one entry per cycle maximum. With tile_ready held high, entries 0..N_TILES-1 appear on N_TILES consecutive cycles.
- tile_pos, tile_idx and tile_last stay stable while tile_valid && !tile_ready.
- done=1 after the edge that completes the handshake on entry N_TILES-1; tile_valid=0 from the same point.
- rewind sampled at edge r: tile_valid=1 and tile_idx=0 after edge r.
- load during SERVE aborts serving: tile_valid=0 after the load edge, then the validation timing above applies.

## Test plan
- Identity order (entry k = k, N=24, W=5), load at edge t, tile_ready=1 -> busy for 24 cycles; tile_valid after edge t+24; tile_pos sequence 0..23 on consecutive cycles; tile_last only with tile_pos=23; done=1 after that handshake.
- Reversed order (entry k = 23-k) with tile_ready toggling 1,0,1,0 -> each entry held stable while ready=0; sequence 23..0, nothing skipped or duplicated; 48 cycles from first valid to done.
- Duplicate: entry 5 = entry 2 = 2 -> error=1 after edge t+6; tile_valid never asserts. A following valid load clears error and serves normally.
- Out-of-range: entry 0 = 31 -> error=1 after edge t+1. Entry 23 = 24 -> error=1 after edge t+24.
- rewind while serving at tile_idx=10 with tile_ready=1 on the same cycle -> tile_idx=0, tile_pos=entry 0 after that edge. rewind in DONE -> replays all 24 entries.
- rst_n pulsed low during CHECK and again during SERVE -> all outputs 0 immediately, state IDLE; rewind afterwards is ignored until the next load.
